// File: rtl/router_ni_flit_tx.sv
// Network-interface flit transmitter: per-packet VC allocation with credit-based flow control.
// Optional sticky protocol-error detection is built when ROUTER_NI_TX_ERROR_CHECK_EN is defined.
module router_ni_flit_tx #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_VCS    = 4,
  parameter int unsigned BUF_DEPTH  = 8,
  parameter int unsigned CHAN_WIDTH = 70
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_head,
  input  logic                        in_tail,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic [CHAN_WIDTH-1:0]       channel_out,
  input  logic [$clog2(NUM_VCS):0]    flow_ctrl_in,
  output logic                        busy,
  output logic                        error
);

  localparam int unsigned VC_IDX_W = $clog2(NUM_VCS);
  localparam int unsigned CRED_W   = $clog2(BUF_DEPTH + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  state_e                            state_q, state_d;
  logic [VC_IDX_W-1:0]               rr_ptr_q, rr_ptr_d;
  logic [VC_IDX_W-1:0]               cur_vc_q, cur_vc_d;
  logic [NUM_VCS-1:0][CRED_W-1:0]    credit_q, credit_d;
  logic [CHAN_WIDTH-1:0]             channel_q, channel_d;

  logic [NUM_VCS-1:0]                has_credit;
  logic [NUM_VCS-1:0]                dec_vec;
  logic [NUM_VCS-1:0]                inc_vec;
  logic [NUM_VCS-1:0]                full_vec;
  logic [VC_IDX_W-1:0]               sel_vc;
  logic [VC_IDX_W-1:0]               cand;
  logic                              sel_found;
  logic [VC_IDX_W-1:0]               send_vc;
  logic                              fire;
  logic                              send;
  logic                              ret_valid;
  logic [VC_IDX_W-1:0]               ret_vc;

  assign ret_valid = flow_ctrl_in[VC_IDX_W];
  assign ret_vc    = flow_ctrl_in[VC_IDX_W-1:0];

  // Credit status and round-robin head allocation starting at rr_ptr.
  always_comb begin
    has_credit = '0;
    full_vec   = '0;
    sel_vc     = rr_ptr_q;
    sel_found  = 1'b0;
    cand       = '0;
    for (int unsigned v = 0; v < NUM_VCS; v++) begin
      has_credit[v] = (credit_q[v] != '0);
      full_vec[v]   = (credit_q[v] == CRED_W'(BUF_DEPTH));
    end
    for (int unsigned i = 0; i < NUM_VCS; i++) begin
      cand = rr_ptr_q + VC_IDX_W'(i);
      if (!sel_found && has_credit[cand]) begin
        sel_vc    = cand;
        sel_found = 1'b1;
      end
    end
  end

  assign in_ready = (state_q == IDLE) ? (|has_credit) : has_credit[cur_vc_q];
  assign fire     = in_valid && in_ready;
  // Non-head flits arriving outside a packet are swallowed.
  assign send     = fire && ((state_q == ACTIVE) || in_head);
  assign send_vc  = (state_q == IDLE) ? sel_vc : cur_vc_q;

  always_comb begin
    dec_vec = '0;
    inc_vec = '0;
    for (int unsigned v = 0; v < NUM_VCS; v++) begin
      dec_vec[v] = send && (send_vc == VC_IDX_W'(v));
      inc_vec[v] = ret_valid && (ret_vc == VC_IDX_W'(v));
    end
  end

  // Next-state, allocation, credit and channel computation.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    cur_vc_d  = cur_vc_q;
    credit_d  = credit_q;
    channel_d = '0;

    if (send) begin
      channel_d = CHAN_WIDTH'({1'b1, (state_q == IDLE), in_tail, send_vc, 1'b0, in_data});
    end

    case (state_q)
      IDLE: begin
        if (send) begin
          cur_vc_d = sel_vc;
          rr_ptr_d = sel_vc + VC_IDX_W'(1);
          if (!in_tail) begin
            state_d = ACTIVE;
          end
        end
      end
      ACTIVE: begin
        if (fire && in_tail) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    for (int unsigned v = 0; v < NUM_VCS; v++) begin
      if (dec_vec[v] && !inc_vec[v]) begin
        credit_d[v] = credit_q[v] - CRED_W'(1);
      end else if (inc_vec[v] && !dec_vec[v] && !full_vec[v]) begin
        credit_d[v] = credit_q[v] + CRED_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      cur_vc_q  <= '0;
      channel_q <= '0;
      for (int unsigned v = 0; v < NUM_VCS; v++) begin
        credit_q[v] <= CRED_W'(BUF_DEPTH);
      end
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      cur_vc_q  <= cur_vc_d;
      channel_q <= channel_d;
      credit_q  <= credit_d;
    end
  end

  assign channel_out = channel_q;
  assign busy        = (state_q == ACTIVE);

`ifdef ROUTER_NI_TX_ERROR_CHECK_EN
  logic error_q, error_d;

  // Sticky flag: stray body flit, nested head, or credit overflow.
  always_comb begin
    error_d = error_q;
    if (fire && (state_q == IDLE) && !in_head) begin
      error_d = 1'b1;
    end
    if (fire && (state_q == ACTIVE) && in_head) begin
      error_d = 1'b1;
    end
    if (|(inc_vec & full_vec)) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_router_ni_flit_tx.sv
// Directed scoreboard bench for router_ni_flit_tx: expected flits queued at drive time,
// popped when the channel shows a valid flit.
module tb_router_ni_flit_tx;

  localparam int unsigned DW = 64;
  localparam int unsigned NV = 4;
  localparam int unsigned BD = 8;
  localparam int unsigned CW = 70;

`ifdef ROUTER_NI_TX_ERROR_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          in_head;
  logic          in_tail;
  logic [DW-1:0] in_data;
  logic [CW-1:0] channel_out;
  logic [2:0]    flow_ctrl_in;
  logic          busy;
  logic          error;

  logic [69:0]   exp_q[$];
  int            checks;
  int            errors;

  router_ni_flit_tx #(
    .DATA_WIDTH(DW),
    .NUM_VCS   (NV),
    .BUF_DEPTH (BD),
    .CHAN_WIDTH(CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_head     (in_head),
    .in_tail     (in_tail),
    .in_data     (in_data),
    .channel_out (channel_out),
    .flow_ctrl_in(flow_ctrl_in),
    .busy        (busy),
    .error       (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [69:0] mk(input logic h, input logic t, input logic [1:0] vc,
                                     input logic [63:0] d);
    return {1'b1, h, t, vc, 1'b0, d};
  endfunction

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic h, input logic t, input logic [63:0] d,
                       input logic [2:0] fc);
    in_valid     = v;
    in_head      = h;
    in_tail      = t;
    in_data      = d;
    flow_ctrl_in = fc;
    #1;
  endtask

  // One clock; then the registered channel is checked against the scoreboard.
  task automatic step();
    @(posedge clk);
    #1;
    if (channel_out[69]) begin
      if (exp_q.size() == 0) chk("unexpected_flit", channel_out, '0);
      else chk("flit", channel_out, exp_q.pop_front());
    end else begin
      chk("idle_channel", channel_out, '0);
    end
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 64'h0, 3'b000);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    logic [63:0] d;
    logic        h;
    logic        t;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 64'h0, 3'b000);
    step();
    do_reset();
    chk("reset_busy", 70'(busy), 70'(0));
    chk("reset_error", 70'(error), 70'(0));
    chk("reset_ready", 70'(in_ready), 70'(1));
    chk("reset_credits", 70'(dut.credit_q), 70'(16'h8888));

    // Single-flit packet on VC0.
    drive(1'b1, 1'b1, 1'b1, 64'hA5, 3'b000);
    exp_q.push_back(mk(1'b1, 1'b1, 2'd0, 64'hA5));
    step();
    drive(1'b0, 1'b0, 1'b0, 64'h0, 3'b000);
    chk("single_credit0", 70'(dut.credit_q[0]), 70'(7));
    chk("single_rr_ptr", 70'(dut.rr_ptr_q), 70'(1));
    chk("single_busy", 70'(busy), 70'(0));

    // Back-to-back 3-flit packets rotate VCs 0,1,2,3,0.
    do_reset();
    for (int p = 0; p < 5; p++) begin
      for (int f = 0; f < 3; f++) begin
        h = (f == 0);
        t = (f == 2);
        d = 64'(32'h200 + 32'(p * 3 + f));
        drive(1'b1, h, t, d, 3'b000);
        exp_q.push_back(mk(h, t, 2'(p % 4), d));
        step();
      end
    end
    drive(1'b0, 1'b0, 1'b0, 64'h0, 3'b000);
    step();
    chk("rr_credits", 70'(dut.credit_q), 70'(16'h5552));

    // Credit exhaustion on VC0 and single credit return.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      h = (i == 0);
      d = 64'(32'h300 + 32'(i));
      drive(1'b1, h, 1'b0, d, 3'b000);
      exp_q.push_back(mk(h, 1'b0, 2'd0, d));
      step();
    end
    drive(1'b1, 1'b0, 1'b0, 64'h308, 3'b000);
    chk("exhausted_ready", 70'(in_ready), 70'(0));
    step();
    step();
    drive(1'b1, 1'b0, 1'b0, 64'h308, 3'b100);
    chk("return_same_cycle_ready", 70'(in_ready), 70'(0));
    step();
    drive(1'b1, 1'b0, 1'b0, 64'h308, 3'b000);
    chk("return_next_cycle_ready", 70'(in_ready), 70'(1));
    exp_q.push_back(mk(1'b0, 1'b0, 2'd0, 64'h308));
    step();
    chk("reexhausted_ready", 70'(in_ready), 70'(0));
    chk("reexhausted_credit", 70'(dut.credit_q[0]), 70'(0));
    drive(1'b0, 1'b0, 1'b0, 64'h0, 3'b000);
    chk("active_busy", 70'(busy), 70'(1));

    // Simultaneous send and return on a VC holding 3 credits.
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b0, 64'h0, 3'b100);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 64'h0, 3'b000);
    chk("credit_three", 70'(dut.credit_q[0]), 70'(3));
    drive(1'b1, 1'b0, 1'b0, 64'h309, 3'b100);
    exp_q.push_back(mk(1'b0, 1'b0, 2'd0, 64'h309));
    step();
    chk("credit_dec_inc", 70'(dut.credit_q[0]), 70'(3));
    drive(1'b1, 1'b0, 1'b1, 64'h30A, 3'b000);
    exp_q.push_back(mk(1'b0, 1'b1, 2'd0, 64'h30A));
    step();
    drive(1'b0, 1'b0, 1'b0, 64'h0, 3'b000);
    chk("tail_credit", 70'(dut.credit_q[0]), 70'(2));
    chk("tail_busy", 70'(busy), 70'(0));
    chk("no_error_yet", 70'(error), 70'(0));

    // Credit return to a full VC saturates.
    drive(1'b0, 1'b0, 1'b0, 64'h0, 3'b110);
    step();
    drive(1'b0, 1'b0, 1'b0, 64'h0, 3'b000);
    chk("saturate_credit2", 70'(dut.credit_q[2]), 70'(8));
    chk("overflow_error", 70'(error), 70'(EXP_ERR));

    // Reset in the middle of a packet.
    do_reset();
    chk("reset_clears_error", 70'(error), 70'(0));
    drive(1'b1, 1'b1, 1'b1, 64'h400, 3'b000);
    exp_q.push_back(mk(1'b1, 1'b1, 2'd0, 64'h400));
    step();
    drive(1'b1, 1'b1, 1'b0, 64'h401, 3'b000);
    exp_q.push_back(mk(1'b1, 1'b0, 2'd1, 64'h401));
    step();
    drive(1'b1, 1'b0, 1'b0, 64'h402, 3'b000);
    exp_q.push_back(mk(1'b0, 1'b0, 2'd1, 64'h402));
    step();
    chk("midpkt_busy", 70'(busy), 70'(1));
    do_reset();
    chk("post_reset_busy", 70'(busy), 70'(0));
    chk("post_reset_credits", 70'(dut.credit_q), 70'(16'h8888));
    drive(1'b1, 1'b1, 1'b1, 64'h500, 3'b000);
    exp_q.push_back(mk(1'b1, 1'b1, 2'd0, 64'h500));
    step();
    drive(1'b0, 1'b0, 1'b0, 64'h0, 3'b000);
    step();

    chk("scoreboard_empty", 70'(exp_q.size()), 70'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
